input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/debounce_pkg.sv | 15 +
 rtl/input_debounce_if.sv | 17 +
 rtl/sync2.sv | 24 ++
 rtl/input_debounce.sv | 100 ++++++++++
 tb/tb_input_debounce.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encodings and defaults for the input debouncer
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW       = 2'b00,
      ST_RISE_WAIT = 2'b01,
      ST_HIGH      = 2'b10,
      ST_FALL_WAIT = 2'b11
   } state_t;

   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_GLITCH_W      = 8;
   localparam int CNT_W             = 8;

endpackage

// File: rtl/input_debounce_if.sv
// rtl/input_debounce_if.sv - raw input and debounced outputs of the debouncer
interface input_debounce_if
   import debounce_pkg::*;
#(
   parameter int GLITCH_W = DEF_GLITCH_W
);

   logic                Raw;
   logic                A;
   logic                Rise;
   logic                Fall;
   logic [GLITCH_W-1:0] GlitchCnt;

   modport master (output Raw, input A, Rise, Fall, GlitchCnt);
   modport slave  (input Raw, output A, Rise, Fall, GlitchCnt);

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous level
module sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - debounce FSM with edge pulses and saturating glitch counter
module input_debounce
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int GLITCH_W      = DEF_GLITCH_W
) (
   input  logic             Clock,
   input  logic             Reset,
   input_debounce_if.slave  bus
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic                w_s2;
   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_a;
   logic                r_rise;
   logic                r_fall;
   logic [GLITCH_W-1:0] r_glitch;

   sync2 u_sync2 (
      .i_clk   (Clock),
      .i_rst_n (Reset),
      .i_d     (bus.Raw),
      .o_q     (w_s2)
   );

   // Outputs are set on the same edge as the state change so A, Rise and Fall line up.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state  <= ST_LOW;
         r_cnt    <= '0;
         r_a      <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_glitch <= '0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            ST_LOW: begin
               if (w_s2) begin
                  r_state <= ST_RISE_WAIT;
                  r_cnt   <= CNT_W'(1);
               end
            end
            ST_RISE_WAIT: begin
               if (w_s2) begin
                  if (r_cnt == LP_LAST) begin
                     r_state <= ST_HIGH;
                     r_cnt   <= '0;
                     r_a     <= 1'b1;
                     r_rise  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else begin
                  r_state <= ST_LOW;
                  r_cnt   <= '0;
                  if (r_glitch != '1) r_glitch <= r_glitch + GLITCH_W'(1);
               end
            end
            ST_HIGH: begin
               if (!w_s2) begin
                  r_state <= ST_FALL_WAIT;
                  r_cnt   <= CNT_W'(1);
               end
            end
            ST_FALL_WAIT: begin
               if (!w_s2) begin
                  if (r_cnt == LP_LAST) begin
                     r_state <= ST_LOW;
                     r_cnt   <= '0;
                     r_a     <= 1'b0;
                     r_fall  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else begin
                  r_state <= ST_HIGH;
                  r_cnt   <= '0;
                  if (r_glitch != '1) r_glitch <= r_glitch + GLITCH_W'(1);
               end
            end
            default: begin
               r_state <= ST_LOW;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.A         = r_a;
   assign bus.Rise      = r_rise;
   assign bus.Fall      = r_fall;
   assign bus.GlitchCnt = r_glitch;

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - directed self-checking bench for input_debounce
module tb_input_debounce;
   import debounce_pkg::*;

   typedef enum logic [1:0] {DS_IDLE, DS_START, DS_STOP, DS_CLEAR} ds_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   rise_cnt;
   int   fall_cnt;
   int   both_cnt;
   logic ds_clr;
   ds_t  ds;

   input_debounce_if #(.GLITCH_W(8)) bus ();

   input_debounce #(.STABLE_CYCLES(4), .GLITCH_W(8)) dut (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.Rise === 1'b1) rise_cnt++;
      if (bus.Fall === 1'b1) fall_cnt++;
      if (bus.Rise === 1'b1 && bus.Fall === 1'b1) both_cnt++;
   end

   // Downstream control FSM driven by A's edge pulses.
   always @(negedge clk) begin
      if (ds_clr) ds <= DS_IDLE;
      else if (bus.Rise === 1'b1 && ds == DS_IDLE)  ds <= DS_START;
      else if (bus.Fall === 1'b1 && ds == DS_START) ds <= DS_STOP;
      else if (bus.Rise === 1'b1 && ds == DS_STOP)  ds <= DS_CLEAR;
      else if (bus.Fall === 1'b1 && ds == DS_CLEAR) ds <= DS_IDLE;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.Raw = 1'b0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.Raw = 1'b1;
      tick(2);
      checks++; if (bus.A !== 1'b0) begin errors++; $display("FAIL reset_a got=%b exp=0", bus.A); end
      checks++; if (bus.Rise !== 1'b0 || bus.Fall !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", bus.Rise, bus.Fall); end
      checks++; if (bus.GlitchCnt !== 8'd0) begin errors++; $display("FAIL reset_glitch got=%0d exp=0", bus.GlitchCnt); end
      checks++; if (dut.r_state !== ST_LOW) begin errors++; $display("FAIL reset_state got=%0d exp=0", dut.r_state); end
      bus.Raw = 1'b0;
      tick(3);
      rst_n = 1'b1;
   endtask

   task automatic test_rise();
      int r0;
      r0 = rise_cnt;
      bus.Raw = 1'b1;
      tick(5);
      checks++; if (bus.A !== 1'b0) begin errors++; $display("FAIL rise_early got=%b exp=0", bus.A); end
      tick(1);
      checks++; if (bus.A !== 1'b1 || bus.Rise !== 1'b1) begin errors++; $display("FAIL rise_edge6 got=A%b R%b exp=A1 R1", bus.A, bus.Rise); end
      tick(1);
      checks++; if (bus.A !== 1'b1 || bus.Rise !== 1'b0) begin errors++; $display("FAIL rise_after got=A%b R%b exp=A1 R0", bus.A, bus.Rise); end
      checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL rise_count got=%0d exp=1", rise_cnt - r0); end
      checks++; if (bus.GlitchCnt !== 8'd0) begin errors++; $display("FAIL rise_glitch got=%0d exp=0", bus.GlitchCnt); end
   endtask

   task automatic test_glitch_fall();
      int f0;
      int lows;
      f0   = fall_cnt;
      lows = 0;
      bus.Raw = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(1); if (bus.A !== 1'b1) lows++; end
      bus.Raw = 1'b1;
      for (int i = 0; i < 8; i++) begin tick(1); if (bus.A !== 1'b1) lows++; end
      checks++; if (lows !== 0) begin errors++; $display("FAIL gfall_hold got=%0d low cycles exp=0", lows); end
      checks++; if (fall_cnt - f0 !== 0) begin errors++; $display("FAIL gfall_nofall got=%0d exp=0", fall_cnt - f0); end
      checks++; if (bus.GlitchCnt !== 8'd1) begin errors++; $display("FAIL gfall_glitch got=%0d exp=1", bus.GlitchCnt); end
      bus.Raw = 1'b0;
      tick(5);
      checks++; if (bus.A !== 1'b1) begin errors++; $display("FAIL fall_early got=%b exp=1", bus.A); end
      tick(1);
      checks++; if (bus.A !== 1'b0 || bus.Fall !== 1'b1 || bus.Rise !== 1'b0) begin errors++; $display("FAIL fall_edge6 got=A%b F%b R%b exp=A0 F1 R0", bus.A, bus.Fall, bus.Rise); end
      tick(2);
      checks++; if (fall_cnt - f0 !== 1) begin errors++; $display("FAIL fall_count got=%0d exp=1", fall_cnt - f0); end
   endtask

   task automatic test_glitch_rise();
      int r0;
      int highs;
      r0    = rise_cnt;
      highs = 0;
      bus.Raw = 1'b1;
      tick(2);
      bus.Raw = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(1); if (bus.A !== 1'b0) highs++; end
      checks++; if (highs !== 0) begin errors++; $display("FAIL grise_hold got=%0d high cycles exp=0", highs); end
      checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL grise_norise got=%0d exp=0", rise_cnt - r0); end
      checks++; if (bus.GlitchCnt !== 8'd2) begin errors++; $display("FAIL grise_glitch got=%0d exp=2", bus.GlitchCnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 254; i++) begin
         bus.Raw = 1'b1; tick(1);
         bus.Raw = 1'b0; tick(3);
      end
      checks++; if (bus.GlitchCnt !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", bus.GlitchCnt); end
      for (int i = 0; i < 46; i++) begin
         bus.Raw = 1'b1; tick(1);
         bus.Raw = 1'b0; tick(3);
      end
      checks++; if (bus.GlitchCnt !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", bus.GlitchCnt); end
      checks++; if (bus.A !== 1'b0) begin errors++; $display("FAIL sat_a got=%b exp=0", bus.A); end
   endtask

   task automatic test_reset_mid();
      int r0;
      do_reset();
      r0 = rise_cnt;
      bus.Raw = 1'b1;
      tick(5);
      checks++; if (dut.r_state !== ST_RISE_WAIT || dut.r_cnt !== 8'd3) begin errors++; $display("FAIL mid_pre got=st%0d cnt%0d exp=st1 cnt3", dut.r_state, dut.r_cnt); end
      rst_n = 1'b0;
      tick(1);
      checks++; if (bus.A !== 1'b0 || bus.Rise !== 1'b0 || bus.Fall !== 1'b0 || bus.GlitchCnt !== 8'd0) begin errors++; $display("FAIL mid_outs got=A%b R%b F%b G%0d exp=A0 R0 F0 G0", bus.A, bus.Rise, bus.Fall, bus.GlitchCnt); end
      checks++; if (dut.r_state !== ST_LOW || dut.r_cnt !== 8'd0) begin errors++; $display("FAIL mid_state got=st%0d cnt%0d exp=st0 cnt0", dut.r_state, dut.r_cnt); end
      rst_n = 1'b1;
      tick(5);
      checks++; if (bus.A !== 1'b0 || rise_cnt - r0 !== 0) begin errors++; $display("FAIL rel_early got=A%b rises%0d exp=A0 rises0", bus.A, rise_cnt - r0); end
      tick(1);
      checks++; if (bus.A !== 1'b1 || bus.Rise !== 1'b1) begin errors++; $display("FAIL rel_edge6 got=A%b R%b exp=A1 R1", bus.A, bus.Rise); end
      checks++; if (bus.GlitchCnt !== 8'd0) begin errors++; $display("FAIL rel_glitch got=%0d exp=0", bus.GlitchCnt); end
   endtask

   task automatic test_downstream();
      ds_t exp_seq [4];
      logic lvl;
      exp_seq = '{DS_START, DS_STOP, DS_CLEAR, DS_IDLE};
      do_reset();
      ds_clr = 1'b1;
      tick(2);
      ds_clr = 1'b0;
      lvl = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lvl = ~lvl;
         bus.Raw = lvl;
         tick(10);
         checks++; if (ds !== exp_seq[i]) begin errors++; $display("FAIL ds_step%0d got=%0d exp=%0d", i, ds, exp_seq[i]); end
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rise_cnt = 0;
      fall_cnt = 0;
      both_cnt = 0;
      ds_clr   = 1'b1;
      rst_n    = 1'b0;
      bus.Raw  = 1'b0;
      test_reset();
      test_rise();
      test_glitch_fall();
      test_glitch_rise();
      test_saturation();
      test_reset_mid();
      test_downstream();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rise_fall_overlap got=%0d exp=0", both_cnt); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
